// File: rtl/trireg_bus_keeper.sv
// trireg_bus_keeper: resolves enabled drivers onto one bus and holds the last value until it decays
module trireg_bus_keeper #(
  parameter int WIDTH = 16,
  parameter int NDRV = 4,
  parameter int DECAY_CYCLES = 50,
  parameter int RESOLVE = 0,
  parameter logic [WIDTH-1:0] DECAY_VAL = '0,
  localparam int CNT_W = $clog2(DECAY_CYCLES + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NDRV-1:0]       drv_en,
  input  logic [NDRV*WIDTH-1:0] drv_data,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      bus_q,
  output logic                  bus_valid,
  output logic                  contention,
  output logic                  contention_err,
  output logic                  decayed,
  output logic [CNT_W-1:0]      hold_cnt
);
  typedef enum logic [1:0] {DRIVEN, HOLD, DECAYED, CONTEND} state_t;
  state_t state;
  logic [WIDTH-1:0] and_v, or_v;
  logic [CNT_W-1:0] cnt_inc;
  logic agree, driven, decay_hit, enter_contend;
  always_comb begin
    and_v = '1;
    or_v = '0;
    for (int i = 0; i < NDRV; i++) begin
      and_v = drv_en[i] ? (and_v & drv_data[i*WIDTH +: WIDTH]) : and_v;
      or_v = drv_en[i] ? (or_v | drv_data[i*WIDTH +: WIDTH]) : or_v;
    end
  end
  // AND equals OR over the enabled set exactly when every enabled driver agrees
  assign agree = and_v == or_v;
  assign driven = |drv_en;
  assign enter_contend = driven && !agree;
  assign cnt_inc = &hold_cnt ? hold_cnt : hold_cnt + CNT_W'(1);
  assign decay_hit = (DECAY_CYCLES > 0) && (cnt_inc == CNT_W'(DECAY_CYCLES));
  assign contention = state == CONTEND;
  assign decayed = state == DECAYED;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DECAYED;
      bus_q <= DECAY_VAL;
      bus_valid <= 1'b0;
      contention_err <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (driven) begin
        hold_cnt <= '0;
        state <= agree ? DRIVEN : CONTEND;
        bus_q <= agree ? and_v : ((RESOLVE != 0) ? or_v : and_v);
        bus_valid <= agree;
      end else if (state != DECAYED) begin
        state <= decay_hit ? DECAYED : HOLD;
        bus_q <= decay_hit ? DECAY_VAL : bus_q;
        bus_valid <= !decay_hit && bus_valid;
        hold_cnt <= decay_hit ? '0 : cnt_inc;
      end
      contention_err <= enter_contend || (contention_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_trireg_bus_keeper.sv
// tb_trireg_bus_keeper: directed and randomized checks of two keeper builds against a behavioural model
module tb_trireg_bus_keeper;
  logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
  logic [3:0] drv_en = '0;
  logic [63:0] drv_data = '0;
  logic [15:0] q, q0;
  logic v, c, e, d, v0, c0, e0, d0;
  logic [5:0] hc;
  logic [0:0] hc0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  trireg_bus_keeper dut (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .err_clr(err_clr),
    .bus_q(q), .bus_valid(v), .contention(c), .contention_err(e), .decayed(d), .hold_cnt(hc)
  );
  trireg_bus_keeper #(.DECAY_CYCLES(0), .RESOLVE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .err_clr(err_clr),
    .bus_q(q0), .bus_valid(v0), .contention(c0), .contention_err(e0), .decayed(d0), .hold_cnt(hc0)
  );

  typedef struct {
    logic [15:0] q;
    bit valid, cont, err, dec;
    int idle;
  } m_t;
  m_t ma, mb;

  function automatic m_t mreset();
    m_t m;
    m.q = '0; m.valid = 0; m.cont = 0; m.err = 0; m.dec = 1; m.idle = 0;
    return m;
  endfunction

  function automatic m_t step(m_t m, int decay, bit res, logic [3:0] en, logic [63:0] data, logic clr);
    logic [15:0] vals[$];
    logic [15:0] r;
    bit same = 1, entering = 0;
    for (int i = 0; i < 4; i++) if (en[i]) vals.push_back(data[i*16 +: 16]);
    if (vals.size() != 0) begin
      foreach (vals[k]) if (vals[k] !== vals[0]) same = 0;
      m.idle = 0; m.dec = 0; m.cont = !same; m.valid = same;
      if (same) m.q = vals[0];
      else begin
        r = res ? 16'h0000 : 16'hFFFF;
        foreach (vals[k]) r = res ? (r | vals[k]) : (r & vals[k]);
        m.q = r;
        entering = 1;
      end
    end else if (!m.dec) begin
      m.cont = 0;
      m.idle++;
      if (decay > 0 && m.idle == decay) begin
        m.dec = 1; m.q = '0; m.valid = 0; m.idle = 0;
      end
    end
    m.err = entering || (m.err && !clr);
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("a_q", 32'(q), 32'(ma.q));
    chk("a_valid", 32'(v), 32'(ma.valid));
    chk("a_cont", 32'(c), 32'(ma.cont));
    chk("a_err", 32'(e), 32'(ma.err));
    chk("a_dec", 32'(d), 32'(ma.dec));
    chk("a_hcnt", 32'(hc), (ma.idle > 63) ? 32'd63 : 32'(ma.idle));
    chk("b_q", 32'(q0), 32'(mb.q));
    chk("b_valid", 32'(v0), 32'(mb.valid));
    chk("b_cont", 32'(c0), 32'(mb.cont));
    chk("b_err", 32'(e0), 32'(mb.err));
    chk("b_dec", 32'(d0), 32'(mb.dec));
    chk("b_hcnt", 32'(hc0), (mb.idle > 1) ? 32'd1 : 32'(mb.idle));
  endtask

  task automatic cycle();
    @(posedge clk);
    ma = step(ma, 50, 0, drv_en, drv_data, err_clr);
    mb = step(mb, 0, 1, drv_en, drv_data, err_clr);
    #1 check_all();
  endtask

  task automatic idle(int n);
    drv_en = '0;
    err_clr = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 ma = mreset();
    mb = mreset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    ma = mreset();
    mb = mreset();
    #12 check_all();
    chk("rst_dec", 32'(d), 32'd1);
    rst_n = 1'b1;
    drv_en = 4'b0001; drv_data = {48'h0, 16'hA5A5};
    cycle();
    chk("t1_q", 32'(q), 32'hA5A5);
    chk("t1_valid", 32'(v), 32'd1);
    idle(49);
    chk("t2_q", 32'(q), 32'hA5A5);
    chk("t2_hcnt", 32'(hc), 32'd49);
    idle(1);
    chk("t2_dec", 32'(d), 32'd1);
    chk("t2_decq", 32'(q), 32'h0);
    drv_en = 4'b0011; drv_data = {32'h0, 16'h0F0F, 16'h00FF};
    cycle();
    chk("t3_q", 32'(q), 32'h000F);
    chk("t3_q_or", 32'(q0), 32'h0FFF);
    chk("t3_err", 32'(e), 32'd1);
    drv_en = '0; err_clr = 1'b1;
    cycle();
    chk("t3_clr", 32'(e), 32'd0);
    chk("t3_valid", 32'(v), 32'd0);
    err_clr = 1'b0;
    drv_en = 4'b0101; drv_data = {16'h0, 16'h1234, 16'h5555, 16'h1234};
    cycle();
    chk("t4_q", 32'(q), 32'h1234);
    chk("t4_cont", 32'(c), 32'd0);
    idle(49);
    drv_en = 4'b0100; drv_data = {16'h0, 16'hBEEF, 32'h0};
    cycle();
    chk("t5_q", 32'(q), 32'hBEEF);
    chk("t5_dec", 32'(d), 32'd0);
    idle(7);
    pulse_reset();
    drv_en = 4'b0001; drv_data = {48'h0, 16'h0001};
    cycle();
    idle(1000);
    chk("t6_q", 32'(q0), 32'h0001);
    chk("t6_valid", 32'(v0), 32'd1);
    chk("t6_hcnt", 32'(hc0), 32'd1);
    for (int b = 0; b < 60; b++) begin
      int len = $urandom_range(1, 70);
      bit quiet = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 15) == 0) pulse_reset();
      for (int k = 0; k < len; k++) begin
        drv_en = (quiet || $urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
        for (int i = 0; i < 4; i++)
          drv_data[i*16 +: 16] = ($urandom_range(0, 1) == 0) ? 16'h1234 : 16'($urandom);
        err_clr = $urandom_range(0, 3) == 0;
        cycle();
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
